perceptron_predictor: RTL

Parametrised perceptron direction predictor with on-chip training. It replaces the fixed 64-entry, 12-history lookup-only predictor in the fetch stage. It accepts fetch lookups by PC, returns a taken/not-taken prediction one cycle later, and maintains a speculative global history register (GHR) with mispredict recovery. It also trains its own weight table from execute-stage resolutions through a read-modify-write FSM.

---
 rtl/perceptron_predictor.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/perceptron_predictor.sv
// perceptron_predictor
//   Perceptron branch-direction predictor with on-chip training.
//   Fetch lookups return a prediction one cycle after acceptance. A
//   speculative global history register (GHR) is kept, and it is
//   recovered on a mispredict. Execute-stage resolutions train the
//   weight table through a read/calc FSM. Each training takes 3 cycles.
// Ports
//   clk, reset             clock; asynchronous active-high reset
//   lookup_valid/_pc/_ready fetch lookup handshake (index = pc[IDX_W+1:2])
//   pred_valid/_taken/_sum/_ghr  prediction, valid one cycle after accept
//   update_valid/_ready/_pc/_taken/_mispredict/_ghr  resolved branch
//   busy                   table clear sweep in progress
//   debug_sel/debug_out    counter select: lookups/updates/trainings/mispredicts
module perceptron_predictor #(
  parameter  int ENTRIES  = 64,
  parameter  int HIST_LEN = 12,
  parameter  int WEIGHT_W = 8,
  parameter  int THETA    = 37,
  localparam int IDX_W    = $clog2(ENTRIES),
  localparam int SUM_W    = WEIGHT_W + $clog2(HIST_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    lookup_valid,
  input  logic [31:0]             lookup_pc,
  output logic                    lookup_ready,
  output logic                    pred_valid,
  output logic                    pred_taken,
  output logic signed [SUM_W-1:0] pred_sum,
  output logic [HIST_LEN-1:0]     pred_ghr,
  input  logic                    update_valid,
  output logic                    update_ready,
  input  logic [31:0]             update_pc,
  input  logic                    update_taken,
  input  logic                    update_mispredict,
  input  logic [HIST_LEN-1:0]     update_ghr,
  output logic                    busy,
  input  logic [1:0]              debug_sel,
  output logic [31:0]             debug_out
);

  localparam int          ROW_W   = (HIST_LEN + 1) * WEIGHT_W;
  localparam logic [31:0] THETA_U = 32'(THETA);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_T_READ, S_T_CALC} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        init_idx_q;
  logic [ROW_W-1:0]        mem [ENTRIES];
  logic [ROW_W-1:0]        rd_data_q;
  logic [IDX_W-1:0]        rd_addr, wr_addr;
  logic                    wr_en;
  logic [ROW_W-1:0]        wr_data;
  logic [IDX_W-1:0]        upd_idx_q;
  logic                    upd_taken_q;
  logic [HIST_LEN-1:0]     upd_ghr_q;
  logic [HIST_LEN-1:0]     ghr_q, ghr_d;
  logic                    pred_valid_q;
  logic [31:0]             lookups_q, updates_q, trainings_q, mispredicts_q;
  logic                    lookup_fire, update_fire;
  logic signed [SUM_W-1:0] lk_sum, tr_sum;
  logic [SUM_W-1:0]        tr_mag;
  logic                    train_need;
  logic [ROW_W-1:0]        trained_row;

  // Perceptron output: bias plus history weights added or subtracted by GHR bit.
  function automatic logic signed [SUM_W-1:0] perc_sum(input logic [ROW_W-1:0] row,
                                                       input logic [HIST_LEN-1:0] g);
    logic signed [SUM_W-1:0]    acc;
    logic signed [SUM_W-1:0]    ext;
    logic        [WEIGHT_W-1:0] w;
    w   = row[WEIGHT_W-1:0];
    acc = {{(SUM_W-WEIGHT_W){w[WEIGHT_W-1]}}, w};
    for (int unsigned k = 0; k < HIST_LEN; k++) begin
      w   = row[(k+1)*WEIGHT_W +: WEIGHT_W];
      ext = {{(SUM_W-WEIGHT_W){w[WEIGHT_W-1]}}, w};
      acc = g[k] ? acc + ext : acc - ext;
    end
    return acc;
  endfunction

  // Saturating +/-1 step of a two's-complement weight.
  function automatic logic [WEIGHT_W-1:0] sat_step(input logic [WEIGHT_W-1:0] w,
                                                   input logic inc);
    logic [WEIGHT_W-1:0] wmax, wmin;
    wmax = {1'b0, {(WEIGHT_W-1){1'b1}}};
    wmin = {1'b1, {(WEIGHT_W-1){1'b0}}};
    if (inc)  return (w == wmax) ? w : w + WEIGHT_W'(1);
    else      return (w == wmin) ? w : w - WEIGHT_W'(1);
  endfunction

  assign lookup_fire = lookup_valid & lookup_ready;
  assign update_fire = update_valid & update_ready;

  // Weight RAM: one registered read port and one write port. Nonblocking
  // semantics give read-before-write on a same-address collision.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_q <= mem[rd_addr];
  end

  always_comb begin
    state_d      = state_q;
    lookup_ready = 1'b0;
    update_ready = 1'b0;
    busy         = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = upd_idx_q;
    wr_data      = trained_row;
    rd_addr      = lookup_pc[IDX_W+1:2];
    unique case (state_q)
      S_INIT: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = init_idx_q;
        wr_data = '0;
        if (init_idx_q == IDX_W'(ENTRIES - 1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        lookup_ready = 1'b1;
        update_ready = 1'b1;
        if (update_valid) state_d = S_T_READ;
      end
      S_T_READ: begin
        rd_addr = upd_idx_q;
        state_d = S_T_CALC;
      end
      S_T_CALC: begin
        lookup_ready = 1'b1;
        wr_en        = train_need;
        state_d      = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  // Training datapath, valid in T_CALC when rd_data_q holds the update row.
  always_comb begin
    tr_sum      = perc_sum(rd_data_q, upd_ghr_q);
    tr_mag      = tr_sum[SUM_W-1] ? -tr_sum : tr_sum;
    train_need  = ((~tr_sum[SUM_W-1]) != upd_taken_q) || (32'(tr_mag) <= THETA_U);
    trained_row = rd_data_q;
    trained_row[WEIGHT_W-1:0] = sat_step(rd_data_q[WEIGHT_W-1:0], upd_taken_q);
    for (int unsigned k = 0; k < HIST_LEN; k++) begin
      trained_row[(k+1)*WEIGHT_W +: WEIGHT_W] =
        sat_step(rd_data_q[(k+1)*WEIGHT_W +: WEIGHT_W], upd_taken_q == upd_ghr_q[k]);
    end
  end

  assign lk_sum     = perc_sum(rd_data_q, ghr_q);
  assign pred_valid = pred_valid_q;
  assign pred_sum   = pred_valid_q ? lk_sum : '0;
  assign pred_taken = pred_valid_q & ~lk_sum[SUM_W-1];
  assign pred_ghr   = ghr_q;

  // Mispredict recovery overrides the speculative shift in the same cycle.
  always_comb begin
    ghr_d = ghr_q;
    if (pred_valid_q)                    ghr_d = {ghr_q[HIST_LEN-2:0], pred_taken};
    if (update_fire && update_mispredict) ghr_d = {update_ghr[HIST_LEN-2:0], update_taken};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_INIT;
      init_idx_q    <= '0;
      pred_valid_q  <= 1'b0;
      ghr_q         <= '0;
      upd_idx_q     <= '0;
      upd_taken_q   <= 1'b0;
      upd_ghr_q     <= '0;
      lookups_q     <= '0;
      updates_q     <= '0;
      trainings_q   <= '0;
      mispredicts_q <= '0;
    end else begin
      state_q      <= state_d;
      pred_valid_q <= lookup_fire;
      ghr_q        <= ghr_d;
      if (state_q == S_INIT) init_idx_q <= init_idx_q + IDX_W'(1);
      if (update_fire) begin
        upd_idx_q   <= update_pc[IDX_W+1:2];
        upd_taken_q <= update_taken;
        upd_ghr_q   <= update_ghr;
      end
      if (lookup_fire) lookups_q <= lookups_q + 32'd1;
      if (update_fire) updates_q <= updates_q + 32'd1;
      if (update_fire && update_mispredict) mispredicts_q <= mispredicts_q + 32'd1;
      if (state_q == S_T_CALC && train_need) trainings_q <= trainings_q + 32'd1;
    end
  end

  always_comb begin
    unique case (debug_sel)
      2'b00:   debug_out = lookups_q;
      2'b01:   debug_out = updates_q;
      2'b10:   debug_out = trainings_q;
      default: debug_out = mispredicts_q;
    endcase
  end

endmodule
